sccb_slave_model: RTL and testbench
===================================

# sccb_slave_model

- Synthesizable SCCB/I2C responder at the far end of the camera configuration bus; emulates an OV5640-style register target.
- Supports 7-bit device address, 16-bit register address and 8-bit data; holds a small register file.
- Answers the camera driver's I2C master in loopback bring-up builds, so configuration sequences can be exercised and probed without a sensor attached.

## Interface
- `DEV_ADDR`, default 7'h3C: 7-bit device address the block acknowledges.
- `AW`, default 6: register-file index width; depth is 2^AW bytes, indexed by reg_addr[AW-1:0].
- `FILT`, default 3: glitch-filter length in clk cycles for SCL/SDA.
- `clk`, in, 1: system clock; must be at least 16× the SCL frequency.
- `rst_n`, in, 1: synchronous, active-low reset.
- `scl_i`, in, 1: bus SCL, asynchronous.
- `sda_i`, in, 1: bus SDA, asynchronous.
- `sda_oe`, out, 1: 1 pulls SDA low; 0 releases it (open-drain).
- `wr_en`, out, 1: one-cycle pulse per register byte written.
- `wr_addr`, out, 16: full register address of the write.
- `wr_data`, out, 8: data of the write.
- `busy`, out, 1: high from an addressed START until STOP or abandon.

## Operation
- Input conditioning:
  - 2-flop synchronizer on each input.
  - Filter updates a line's level only after FILT equal consecutive samples.
  - Edge flags are derived from the filtered levels.
- Bus conditions:
  - START = SDA falls while SCL high; STOP = SDA rises while SCL high.
  - START in any state → DEVA (repeated START supported); STOP in any state → IDLE.
- Data timing: bits are sampled on SCL rise; the slave changes `sda_oe` only on SCL fall.
- FSM states: IDLE, DEVA, ACK_D, RAH, ACK_H, RAL, ACK_L, WDAT, ACK_W, RDAT, MACK.
- Write path:
  - DEVA shifts 8 bits. On match with R/W=0, or R/W=1, go to ACK_D and drive ACK; no match → IDLE, bus untouched until the next START.
  - ACK_D (write) → RAH → ACK_H → RAL → ACK_L → WDAT.
  - Each completed WDAT byte writes the register file, pulses `wr_en`, then ACK_W → WDAT.
- Read path:
  - ACK_D (read) → RDAT.
  - RDAT drives bits MSB first from mem[ptr]; `sda_oe` = ~bit.
  - After 8 bits, release SDA → MACK and sample the master's bit.
  - 0 (ACK) → RDAT with the next byte; 1 (NACK) → IDLE.
- Address pointer: 16-bit `ptr`, loaded from RAH/RAL; persists across transactions, so STOP+START reads (SCCB style) work.
- ACK timing: `sda_oe` asserts on the SCL fall ending bit 8 and releases on the next SCL fall.
- Pointer arithmetic: `ptr` wraps 16'hFFFF → 16'h0000; register-file index wraps modulo 2^AW.

## Timing
- Input to internal edge latency: 2 + FILT clk cycles.
- `wr_en` asserts 1 cycle after the internal SCL rise of data bit 0 (LSB). `wr_addr`/`wr_data` are valid in the same cycle and held until the next write.
- `sda_oe` changes within 1 cycle of the internal SCL fall.
- Reset values: `sda_oe`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, state IDLE, `ptr`=0.
- Register file is not cleared by reset (RAM inference).
- Reset asserted mid-transfer: SDA released on the next cycle; the partial byte is discarded with no `wr_en`.
- START while driving a read bit: release immediately, enter DEVA.
- STOP in the middle of a byte: partial byte dropped, no write.

## Configuration
- `SCCB_SLV_AUTOINC_EN`
  - Defined: `ptr` increments after every written byte and every read byte acknowledged by the master; bursts fill/read consecutive registers.
  - Undefined: `ptr` stays fixed. Burst writes overwrite the same register, each still producing a `wr_en`; burst reads return the same byte.

## Test plan
- Single write: START, 0x78, 0x30, 0x08, 0x82, STOP → four ACKs (`sda_oe` high on each 9th clock); one `wr_en` with addr 0x3008, data 0x82; `busy` low after STOP.
- Readback: write 0x3008, STOP, START 0x79, master NACK → slave drives 0x82; SDA released at MACK; state IDLE.
- Address mismatch: START, 0x7A, ... → `sda_oe` never asserts; no `wr_en`; next START with 0x78 is acknowledged normally.
- Burst with AUTOINC on: write 0x3000 data 0x11,0x22,0x33 → `wr_en` at 0x3000/0x3001/0x3002. Read burst of 3 with ACK,ACK,NACK returns 11,22,33. With macro off, all writes land at 0x3000.
- Abort: STOP after 4 data bits → no `wr_en`, `busy`=0. Repeated START mid-RDAT → SDA released within 1 cycle.
- Reset mid-read: `rst_n` low for 1 cycle while driving a 0 bit → `sda_oe`=0 next cycle, state IDLE, `ptr`=0.

Source files
------------

// File: rtl/sccb_slave_model.sv
`default_nettype none
// ============================================================================
// Module   : sccb_slave_model
// Purpose  : SCCB/I2C register target (7-bit device address, 16-bit register
//            address, 8-bit data) for camera-bus loopback bring-up.
//            Optional macro SCCB_SLV_AUTOINC_EN enables pointer auto-increment.
// Revision : 1.0  initial release
// ============================================================================
module sccb_slave_model #(
    parameter logic [6:0] DEV_ADDR = 7'h3C,
    parameter int         AW       = 6,
    parameter int         FILT     = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_oe,
    output logic        wr_en,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        busy
);
`ifdef SCCB_SLV_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif
    localparam int            CW        = (FILT > 1) ? $clog2(FILT) : 1;
    localparam logic [CW-1:0] FILT_LAST = CW'(FILT - 1);

    typedef enum logic [3:0] {
        IDLE, DEVA, ACK_D, RAH, ACK_H, RAL, ACK_L, WDAT, ACK_W, RDAT, MACK
    } state_t;

    // Index 0 carries SCL, index 1 carries SDA through sync and filter.
    logic [1:0]    sync1_q, sync2_q, flt_q, flt_d, prev_q;
    logic [CW-1:0] fcnt_q [2];
    logic [CW-1:0] fcnt_d [2];

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            flt_d[i]  = flt_q[i];
            fcnt_d[i] = '0;
            if (sync2_q[i] != flt_q[i]) begin
                if (fcnt_q[i] == FILT_LAST) flt_d[i] = sync2_q[i];
                else                        fcnt_d[i] = fcnt_q[i] + CW'(1);
            end
        end
    end

    logic scl_rise, scl_fall, start_c, stop_c;
    assign scl_rise = flt_q[0] & ~prev_q[0];
    assign scl_fall = ~flt_q[0] & prev_q[0];
    assign start_c  = flt_q[0] & prev_q[0] & prev_q[1] & ~flt_q[1];
    assign stop_c   = flt_q[0] & prev_q[0] & ~prev_q[1] & flt_q[1];

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  sh_q, sh_d, hi_q, hi_d;
    logic        rw_q, rw_d;
    logic [15:0] ptr_q, ptr_d;
    logic        sda_oe_q, sda_oe_d, wr_en_q, wr_en_d;
    logic [15:0] wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        mem_we;
    logic [7:0]  sh_in, rdata;
    logic [7:0]  mem [2**AW];

    assign sh_in = {sh_q[6:0], flt_q[1]};
    assign rdata = mem[ptr_q[AW-1:0]];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        hi_d      = hi_q;
        rw_d      = rw_q;
        ptr_d     = ptr_q;
        sda_oe_d  = sda_oe_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        mem_we    = 1'b0;
        if (stop_c) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            cnt_d    = '0;
        end else if (start_c) begin
            state_d  = DEVA;
            sda_oe_d = 1'b0;
            cnt_d    = '0;
        end else begin
            case (state_q)
                DEVA, RAH, RAL, WDAT: begin
                    if (scl_rise && cnt_q != 4'd8) begin
                        sh_d  = sh_in;
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            if (state_q == RAH) hi_d = sh_in;
                            if (state_q == RAL) ptr_d = {hi_q, sh_in};
                            if (state_q == WDAT) begin
                                mem_we    = 1'b1;
                                wr_en_d   = 1'b1;
                                wr_addr_d = ptr_q;
                                wr_data_d = sh_in;
                                if (AUTOINC) ptr_d = ptr_q + 16'd1;
                            end
                        end
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        cnt_d    = '0;
                        sda_oe_d = 1'b1;
                        if (state_q == DEVA) begin
                            if (sh_q[7:1] == DEV_ADDR) begin
                                rw_d    = sh_q[0];
                                state_d = ACK_D;
                            end else begin
                                // Foreign address: stay off the bus until next START.
                                state_d  = IDLE;
                                sda_oe_d = 1'b0;
                            end
                        end else if (state_q == RAH) state_d = ACK_H;
                        else if (state_q == RAL)     state_d = ACK_L;
                        else                         state_d = ACK_W;
                    end
                end
                ACK_D, ACK_H, ACK_L, ACK_W: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        cnt_d    = '0;
                        if (state_q == ACK_D) begin
                            if (rw_q) begin
                                state_d  = RDAT;
                                sh_d     = rdata;
                                sda_oe_d = ~rdata[7];
                            end else begin
                                state_d = RAH;
                            end
                        end else if (state_q == ACK_H) state_d = RAL;
                        else                           state_d = WDAT;
                    end
                end
                RDAT: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            cnt_d    = '0;
                            state_d  = MACK;
                        end else begin
                            sh_d     = {sh_q[6:0], 1'b0};
                            sda_oe_d = ~sh_q[6];
                        end
                    end
                end
                MACK: begin
                    // sh_q[0] holds the master's acknowledge bit after the rise.
                    if (scl_rise) begin
                        sh_d = sh_in;
                        if (AUTOINC && !flt_q[1]) ptr_d = ptr_q + 16'd1;
                    end else if (scl_fall) begin
                        if (!sh_q[0]) begin
                            state_d  = RDAT;
                            sh_d     = rdata;
                            sda_oe_d = ~rdata[7];
                            cnt_d    = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q   <= 2'b11;
            sync2_q   <= 2'b11;
            flt_q     <= 2'b11;
            prev_q    <= 2'b11;
            fcnt_q[0] <= '0;
            fcnt_q[1] <= '0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            sh_q      <= '0;
            hi_q      <= '0;
            rw_q      <= 1'b0;
            ptr_q     <= '0;
            sda_oe_q  <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            sync1_q   <= {sda_i, scl_i};
            sync2_q   <= sync1_q;
            flt_q     <= flt_d;
            prev_q    <= flt_q;
            fcnt_q[0] <= fcnt_d[0];
            fcnt_q[1] <= fcnt_d[1];
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sh_q      <= sh_d;
            hi_q      <= hi_d;
            rw_q      <= rw_d;
            ptr_q     <= ptr_d;
            sda_oe_q  <= sda_oe_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[ptr_q[AW-1:0]] <= sh_in;
    end

    assign sda_oe  = sda_oe_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sccb_slave_model.sv
`default_nettype none
// ============================================================================
// Module   : tb_sccb_slave_model
// Purpose  : Self-checking bench for sccb_slave_model; drives an I2C master.
// Revision : 1.0  initial release
// ============================================================================
module tb_sccb_slave_model;
    localparam int Q = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scl_m = 1'b1;
    logic        sda_m = 1'b1;
    logic        sda_bus;
    logic        sda_oe, wr_en, busy;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;

    assign sda_bus = sda_m & ~sda_oe;

    sccb_slave_model dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .scl_i   (scl_m),
        .sda_i   (sda_bus),
        .sda_oe  (sda_oe),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          wr_cnt = 0;
    int          oe_cnt = 0;
    logic [23:0] wlog [64];

    always @(negedge clk) begin
        if (wr_en) begin
            if (wr_cnt < 64) wlog[wr_cnt] = {wr_addr, wr_data};
            wr_cnt = wr_cnt + 1;
        end
        if (sda_oe) oe_cnt = oe_cnt + 1;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tq(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start;
        sda_m = 1'b1; tq(Q);
        scl_m = 1'b1; tq(Q);
        sda_m = 1'b0; tq(Q);
        scl_m = 1'b0; tq(Q);
    endtask

    task automatic bus_stop;
        sda_m = 1'b0; tq(Q);
        scl_m = 1'b1; tq(Q);
        sda_m = 1'b1; tq(Q);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            sda_m = b[i]; tq(Q);
            scl_m = 1'b1; tq(2 * Q);
            scl_m = 1'b0; tq(Q);
        end
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        send_bits(b, 8);
        sda_m = 1'b1; tq(Q);
        scl_m = 1'b1; tq(Q);
        ack = sda_oe; tq(Q);
        scl_m = 1'b0; tq(Q);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] b, output logic oe_mack);
        for (int i = 7; i >= 0; i--) begin
            tq(Q);
            scl_m = 1'b1; tq(Q);
            b[i] = sda_bus; tq(Q);
            scl_m = 1'b0;
        end
        tq(Q);
        sda_m = nack; tq(Q);
        scl_m = 1'b1; tq(Q);
        oe_mack = sda_oe; tq(Q);
        scl_m = 1'b0; tq(2);
        sda_m = 1'b1; tq(Q - 2);
    endtask

    task automatic set_ptr(input logic [15:0] a);
        logic k;
        bus_start;
        write_byte(8'h78, k);
        write_byte(a[15:8], k);
        write_byte(a[7:0], k);
        bus_stop;
    endtask

    typedef struct {
        logic [7:0]  dev, ahi, alo, dat;
        logic [3:0]  acks;
        int          nwr;
    } wvec_t;

    initial begin
        wvec_t       vt [5];
        logic [3:0]  a;
        logic        k, om;
        logic [7:0]  rb;
        logic [7:0]  exp_rd [3];
        logic [15:0] exp_wa [3];
        int          base, obase;

        vt[0] = '{8'h78, 8'h30, 8'h08, 8'h82, 4'b1111, 1};
        vt[1] = '{8'h78, 8'h12, 8'h05, 8'h5A, 4'b1111, 1};
        vt[2] = '{8'h7A, 8'h30, 8'h08, 8'hFF, 4'b0000, 0};
        vt[3] = '{8'h78, 8'hFF, 8'h3F, 8'hC3, 4'b1111, 1};
        vt[4] = '{8'h78, 8'h00, 8'h01, 8'hA5, 4'b1111, 1};
`ifdef SCCB_SLV_AUTOINC_EN
        exp_rd = '{8'h11, 8'h22, 8'h33};
        exp_wa = '{16'h3000, 16'h3001, 16'h3002};
`else
        exp_rd = '{8'h33, 8'h33, 8'h33};
        exp_wa = '{16'h3000, 16'h3000, 16'h3000};
`endif

        tq(4);
        check("reset sda_oe", sda_oe, 0);
        check("reset wr_en", wr_en, 0);
        check("reset wr_addr", wr_addr, 0);
        check("reset wr_data", wr_data, 0);
        check("reset busy", busy, 0);
        rst_n = 1'b1;
        tq(4);

        // A one-cycle SDA dip while SCL is high must not look like START.
        sda_m = 1'b0; tq(1);
        sda_m = 1'b1; tq(Q);
        check("glitch busy", busy, 0);

        for (int v = 0; v < 5; v++) begin
            base  = wr_cnt;
            obase = oe_cnt;
            bus_start;
            write_byte(vt[v].dev, a[3]);
            write_byte(vt[v].ahi, a[2]);
            write_byte(vt[v].alo, a[1]);
            write_byte(vt[v].dat, a[0]);
            bus_stop;
            check($sformatf("vec%0d acks", v), a, vt[v].acks);
            check($sformatf("vec%0d wr count", v), wr_cnt - base, vt[v].nwr);
            check($sformatf("vec%0d oe seen", v), (oe_cnt != obase), (vt[v].acks != 0));
            check($sformatf("vec%0d busy", v), busy, 0);
            if (vt[v].nwr == 1) begin
                check($sformatf("vec%0d wr addr", v), wlog[base][23:8], {vt[v].ahi, vt[v].alo});
                check($sformatf("vec%0d wr data", v), wlog[base][7:0], vt[v].dat);
                check($sformatf("vec%0d addr hold", v), wr_addr, {vt[v].ahi, vt[v].alo});
            end
        end

        // Readback of 0x3008 with master NACK.
        set_ptr(16'h3008);
        bus_start;
        write_byte(8'h79, k);
        check("rd devack", k, 1);
        read_byte(1'b1, rb, om);
        check("rd data", rb, 8'h82);
        check("rd mack release", om, 0);
        check("rd idle after nack", busy, 0);
        bus_stop;

        // Burst write then burst read ACK, ACK, NACK.
        base = wr_cnt;
        bus_start;
        write_byte(8'h78, k); write_byte(8'h30, k); write_byte(8'h00, k);
        write_byte(8'h11, k); write_byte(8'h22, k); write_byte(8'h33, k);
        bus_stop;
        check("burst wr count", wr_cnt - base, 3);
        for (int i = 0; i < 3; i++)
            check($sformatf("burst wr addr%0d", i), wlog[base + i][23:8], exp_wa[i]);
        check("burst wr data2", wlog[base + 2][7:0], 8'h33);
        set_ptr(16'h3000);
        bus_start;
        write_byte(8'h79, k);
        for (int i = 0; i < 3; i++) begin
            read_byte((i == 2), rb, om);
            check($sformatf("burst rd%0d", i), rb, exp_rd[i]);
        end
        bus_stop;

        // STOP after four data bits.
        base = wr_cnt;
        bus_start;
        write_byte(8'h78, k); write_byte(8'h30, k); write_byte(8'h08, k);
        send_bits(8'hF0, 4);
        bus_stop;
        check("abort no write", wr_cnt - base, 0);
        check("abort busy", busy, 0);

        // Repeated START while the slave is in a read byte (bit 7 = 1).
        set_ptr(16'h3008);
        bus_start;
        write_byte(8'h79, k);
        tq(Q);
        scl_m = 1'b1; tq(Q);
        check("restart bit7 released", sda_oe, 0);
        sda_m = 1'b0; tq(Q);
        scl_m = 1'b0; tq(Q);
        check("restart no bit6 drive", sda_oe, 0);
        write_byte(8'h78, k);
        check("restart devack", k, 1);
        write_byte(8'h30, k); write_byte(8'h08, k);
        bus_stop;

        // Reset while the slave is driving a 0 bit (bit 6 of 0x82).
        bus_start;
        write_byte(8'h79, k);
        tq(Q);
        scl_m = 1'b1; tq(2 * Q);
        scl_m = 1'b0; tq(Q);
        check("rst drive0 before", sda_oe, 1);
        rst_n = 1'b0; tq(1);
        check("rst sda released", sda_oe, 0);
        check("rst busy", busy, 0);
        check("rst wr_addr", wr_addr, 0);
        rst_n = 1'b1; tq(Q);
        bus_stop;
        bus_start;
        write_byte(8'h79, k);
        read_byte(1'b1, rb, om);
        check("rst ptr zero", rb, exp_rd[0]);
        bus_stop;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
